// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle ARM controller and its datapath.
// The master is the controller; the slave is the datapath side.
interface multicycle_controller_if;
  logic [31:12] Instr;
  logic [3:0]   ALUFlags;
  logic         PCWrite;
  logic         RegWrite;
  logic         MemWrite;
  logic         IRWrite;
  logic         AdrSrc;
  logic [1:0]   RegSrc;
  logic [1:0]   ALUSrcA;
  logic [1:0]   ALUSrcB;
  logic [1:0]   ResultSrc;
  logic [1:0]   ImmSrc;
  logic [1:0]   ALUControl;
  logic [3:0]   state;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, RegSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, state
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, RegSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: FETCH..writeback sequencer, NZCV flag register
// and condition evaluation driving every datapath select and enable.
module multicycle_controller #(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input logic                    clk,
  input logic                    reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ok_q, cond_ok_d;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] unused_rn;

  assign cond      = bus.Instr[31:28];
  assign op        = bus.Instr[27:26];
  assign funct     = bus.Instr[25:20];
  assign rd        = bus.Instr[15:12];
  assign unused_rn = bus.Instr[19:16];

  function automatic logic cond_ex(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = cy;
      4'b0011: cond_ex = ~cy;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = cy & ~z;
      4'b1001: cond_ex = ~cy | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  endfunction

  logic [1:0] alu_ctrl;
  logic       cmd_ok;
  logic       cmd_arith;

  always_comb begin
    alu_ctrl  = 2'b00;
    cmd_ok    = 1'b1;
    cmd_arith = 1'b0;
    case (funct[4:1])
      4'b0100: begin alu_ctrl = 2'b00; cmd_arith = 1'b1; end
      4'b0010: begin alu_ctrl = 2'b01; cmd_arith = 1'b1; end
      4'b0000: alu_ctrl = 2'b10;
      4'b1100: alu_ctrl = 2'b11;
      default: cmd_ok = 1'b0;
    endcase
  end

  logic       ir_w, adr_src, reg_w, mem_w, branch;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_control;

  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    cond_ok_d   = cond_ok_q;
    ir_w        = 1'b0;
    adr_src     = 1'b0;
    reg_w       = 1'b0;
    mem_w       = 1'b0;
    branch      = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_w       = 1'b1;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        cond_ok_d  = cond_ex(cond, flags_q);
        case (op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = !cmd_ok ? S_FETCH : (funct[5] ? S_EXECI : S_EXECR);
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_b = 2'b01;
        state_d   = funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        alu_src_b   = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        alu_control = alu_ctrl;
        // C and V are only meaningful for add/sub; logical ops keep them.
        if (cond_ok_q && funct[0]) begin
          flags_d[3:2] = bus.ALUFlags[3:2];
          if (cmd_arith) flags_d[1:0] = bus.ALUFlags[1:0];
        end
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      flags_q   <= FLAGS_RESET;
      cond_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cond_ok_q <= cond_ok_d;
    end
  end

  assign bus.PCWrite    = ~reset & ((state_q == S_FETCH) |
                          (cond_ok_q & (branch | (reg_w & (rd == 4'hF)))));
  assign bus.RegWrite   = ~reset & reg_w & cond_ok_q;
  assign bus.MemWrite   = ~reset & mem_w & cond_ok_q;
  assign bus.IRWrite    = ~reset & ir_w;
  assign bus.AdrSrc     = adr_src;
  assign bus.RegSrc     = {op == 2'b01, op == 2'b10};
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ResultSrc  = result_src;
  assign bus.ImmSrc     = op;
  assign bus.ALUControl = alu_control;
  assign bus.state      = state_q;

endmodule
